// File: rtl/alu_issue_unit_if.sv
// Decode, ALU-drive and write-back signals of the ALU issue unit.
// The master modport is the issue unit; the slave modport is its surroundings.
interface alu_issue_unit_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_rd;

  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  logic [2:0]   alu_flag;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [2:0]   res_rd;
  logic         res_wb;

  modport master (
    input  in_valid, in_op, in_a, in_b, in_rd, alu_out, alu_flag, res_ready,
    output in_ready, alu_in1, alu_in2, alu_ctrl, res_valid, res_data, res_rd, res_wb
  );

  modport slave (
    output in_valid, in_op, in_a, in_b, in_rd, alu_out, alu_flag, res_ready,
    input  in_ready, alu_in1, alu_in2, alu_ctrl, res_valid, res_data, res_rd, res_wb
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Execute-stage issue unit: buffers decoded ops in a FIFO, drives the combinational
// ALU from a registered EX stage, and holds the result plus CCR for write-back.
module alu_issue_unit #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_unit_if.master bus,
  output logic [2:0]       ccr,
  output logic             err_illegal,
  output logic             busy
);
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_STD = 3'b100;
  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CW     = AW + 1;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   rd;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          adv_ex;
  logic          adv_res;
  logic          head_legal;
  logic          head_illegal;

  logic          ex_valid;
  logic [2:0]    ex_op;
  logic [W-1:0]  ex_a;
  logic [W-1:0]  ex_b;
  logic [2:0]    ex_rd;

  logic          res_valid;
  logic [W-1:0]  res_data;
  logic [2:0]    res_rd;
  logic          res_wb;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign push         = bus.in_valid && !full;
  assign adv_res      = !res_valid || bus.res_ready;
  assign adv_ex       = !ex_valid || adv_res;
  assign pop          = !empty && adv_ex;
  assign head         = mem[rd_ptr];
  assign head_legal   = (head.op != OP_NOP) && (head.op <= OP_STD);
  assign head_illegal = (head.op > OP_STD);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count gates every read, so
  // stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_t'{bus.in_op, bus.in_a, bus.in_b, bus.in_rd};
  end

  // EX stage: NOPs and illegal opcodes consume the issue slot but load nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_op       <= OP_NOP;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_rd       <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= pop && head_illegal;
      if (adv_ex) begin
        if (pop && head_legal) begin
          ex_valid <= 1'b1;
          ex_op    <= head.op;
          ex_a     <= head.a;
          ex_b     <= head.b;
          ex_rd    <= head.rd;
        end else begin
          ex_valid <= 1'b0;
          ex_op    <= OP_NOP;
        end
      end
    end
  end

  // RES stage and CCR share the capture edge so ccr always matches the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_wb    <= 1'b0;
      ccr       <= '0;
    end else if (ex_valid && adv_res) begin
      res_valid <= 1'b1;
      res_data  <= bus.alu_out;
      res_rd    <= ex_rd;
      res_wb    <= (ex_op != OP_STD);
      case (ex_op)
        OP_ADD: ccr <= {bus.alu_out[W-1], bus.alu_flag[1], (bus.alu_out == '0)};
        OP_NOT: begin
          ccr[2] <= bus.alu_out[W-1];
          ccr[0] <= (bus.alu_out == '0);
        end
        default: ;
      endcase
    end else if (bus.res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.alu_in1   = ex_a;
  assign bus.alu_in2   = ex_b;
  assign bus.alu_ctrl  = ex_op;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_rd    = res_rd;
  assign bus.res_wb    = res_wb;
  assign busy          = !empty || ex_valid || res_valid;
endmodule
